// File: rtl/multicycle_control.sv
// Main control sequencer for the MIPS32 multi-cycle datapath (addi support via MULTICYCLE_CTRL_ADDI_EN).
// Latency: 3 to 5 cycles per instruction; outputs are decoded from the state within the same cycle.
// Backpressure: FETCH, MEM_RD and MEM_WR hold their state and strobes until mem_ready is high.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_en,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EX     = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9
`ifdef MULTICYCLE_CTRL_ADDI_EN
        ,
        ADDI_EX  = 4'd10,
        ADDI_WB  = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;

    state_t cur_state;
    state_t nxt_state;

    assign state = cur_state;

    always_comb begin
        nxt_state = FETCH;
        case (cur_state)
            FETCH:    nxt_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nxt_state = MEM_ADDR;
                    OP_RTYPE:     nxt_state = R_EX;
                    OP_BEQ:       nxt_state = BRANCH;
                    OP_J:         nxt_state = JUMP;
`ifdef MULTICYCLE_CTRL_ADDI_EN
                    OP_ADDI:      nxt_state = ADDI_EX;
`endif
                    default:      nxt_state = FETCH;
                endcase
            end
            MEM_ADDR: nxt_state = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:   nxt_state = mem_ready ? MEM_WB : MEM_RD;
            MEM_WB:   nxt_state = FETCH;
            MEM_WR:   nxt_state = mem_ready ? FETCH : MEM_WR;
            R_EX:     nxt_state = R_WB;
            R_WB:     nxt_state = FETCH;
            BRANCH:   nxt_state = FETCH;
            JUMP:     nxt_state = FETCH;
`ifdef MULTICYCLE_CTRL_ADDI_EN
            ADDI_EX:  nxt_state = ADDI_WB;
            ADDI_WB:  nxt_state = FETCH;
`endif
            default:  nxt_state = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = ALU_ADD;
        illegal_op    = 1'b0;
        case (cur_state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: illegal_op = 1'b0;
`ifdef MULTICYCLE_CTRL_ADDI_EN
                    OP_ADDI:                              illegal_op = 1'b0;
`endif
                    default:                              illegal_op = 1'b1;
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            R_EX: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
`ifdef MULTICYCLE_CTRL_ADDI_EN
            ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            ADDI_WB: begin
                reg_write = 1'b1;
            end
`endif
            default: begin
                alu_op = ALU_ADD;
            end
        endcase
        // The state is already FETCH under reset; only the write strobes need masking.
        if (reset) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            mem_write  = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign pc_en = pc_write | (pc_write_cond & zero);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control: reset, lw, sw with stalls, beq, R-type, j, illegal and addi opcodes.
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_en;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       illegal_op;
    logic [3:0] state;

    int n_cmp;
    int n_bad;

    multicycle_control dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_en         (pc_en),
        .pc_source     (pc_source),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it before driving or checking.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int wr_cycles;

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        opcode    = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #3;
        chk("rst_state",     32'(state), 32'd0);
        chk("rst_ir_write",  32'(ir_write), 32'd0);
        chk("rst_pc_write",  32'(pc_write), 32'd0);
        chk("rst_pc_en",     32'(pc_en), 32'd0);
        chk("rst_mem_read",  32'(mem_read), 32'd1);
        chk("rst_alu_src_b", 32'(alu_src_b), 32'd1);
        tick();
        chk("rst_hold_state", 32'(state), 32'd0);
        reset = 1'b0;
        #1;

        // lw with mem_ready held high: 0,1,2,3,4,0
        opcode = 6'b100011;
        chk("lw_f_state",    32'(state), 32'd0);
        chk("lw_f_ir_write", 32'(ir_write), 32'd1);
        chk("lw_f_pc_en",    32'(pc_en), 32'd1);
        chk("lw_f_regw",     32'(reg_write), 32'd0);
        tick();
        chk("lw_d_state",     32'(state), 32'd1);
        chk("lw_d_alu_src_b", 32'(alu_src_b), 32'd3);
        chk("lw_d_illegal",   32'(illegal_op), 32'd0);
        chk("lw_d_regw",      32'(reg_write), 32'd0);
        tick();
        chk("lw_a_state",     32'(state), 32'd2);
        chk("lw_a_alu_src_a", 32'(alu_src_a), 32'd1);
        chk("lw_a_alu_src_b", 32'(alu_src_b), 32'd2);
        chk("lw_a_regw",      32'(reg_write), 32'd0);
        tick();
        chk("lw_r_state",    32'(state), 32'd3);
        chk("lw_r_mem_read", 32'(mem_read), 32'd1);
        chk("lw_r_i_or_d",   32'(i_or_d), 32'd1);
        chk("lw_r_m2r",      32'(mem_to_reg), 32'd0);
        chk("lw_r_regw",     32'(reg_write), 32'd0);
        tick();
        chk("lw_wb_state", 32'(state), 32'd4);
        chk("lw_wb_regw",  32'(reg_write), 32'd1);
        chk("lw_wb_m2r",   32'(mem_to_reg), 32'd1);
        chk("lw_wb_rdst",  32'(reg_dst), 32'd0);
        tick();
        chk("lw_end_state", 32'(state), 32'd0);

        // FETCH stall: no IR/PC load while mem_ready is low
        mem_ready = 1'b0;
        #1;
        chk("fstall_ir_write", 32'(ir_write), 32'd0);
        chk("fstall_pc_en",    32'(pc_en), 32'd0);
        chk("fstall_mem_read", 32'(mem_read), 32'd1);
        tick();
        chk("fstall_state", 32'(state), 32'd0);

        // sw with three wait cycles in MEM_WR
        opcode    = 6'b101011;
        mem_ready = 1'b1;
        tick();
        tick();
        chk("sw_a_state", 32'(state), 32'd2);
        mem_ready = 1'b0;
        tick();
        wr_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            chk("sw_wait_state", 32'(state), 32'd5);
            chk("sw_wait_i_or_d", 32'(i_or_d), 32'd1);
            if (mem_write === 1'b1) wr_cycles++;
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("sw_last_state", 32'(state), 32'd5);
        if (mem_write === 1'b1) wr_cycles++;
        chk("sw_write_cycles", 32'(wr_cycles), 32'd4);
        tick();
        chk("sw_end_state",  32'(state), 32'd0);
        chk("sw_end_mem_wr", 32'(mem_write), 32'd0);

        // beq: pc_en follows zero within the BRANCH cycle
        opcode = 6'b000100;
        tick();
        tick();
        zero = 1'b1;
        #1;
        chk("beq_state",     32'(state), 32'd8);
        chk("beq_z1_pc_en",  32'(pc_en), 32'd1);
        chk("beq_pc_source", 32'(pc_source), 32'd1);
        chk("beq_alu_op",    32'(alu_op), 32'd1);
        chk("beq_pc_write",  32'(pc_write), 32'd0);
        zero = 1'b0;
        #1;
        chk("beq_z0_pc_en", 32'(pc_en), 32'd0);
        tick();
        chk("beq_end_state", 32'(state), 32'd0);

        // R-type
        opcode = 6'b000000;
        tick();
        tick();
        chk("r_ex_state",  32'(state), 32'd6);
        chk("r_ex_alu_op", 32'(alu_op), 32'd2);
        chk("r_ex_src_b",  32'(alu_src_b), 32'd0);
        chk("r_ex_regw",   32'(reg_write), 32'd0);
        tick();
        chk("r_wb_state", 32'(state), 32'd7);
        chk("r_wb_rdst",  32'(reg_dst), 32'd1);
        chk("r_wb_regw",  32'(reg_write), 32'd1);
        chk("r_wb_m2r",   32'(mem_to_reg), 32'd0);
        tick();
        chk("r_end_state", 32'(state), 32'd0);

        // j
        opcode = 6'b000010;
        tick();
        tick();
        chk("j_state",     32'(state), 32'd9);
        chk("j_pc_en",     32'(pc_en), 32'd1);
        chk("j_pc_source", 32'(pc_source), 32'd2);
        tick();
        chk("j_end_state", 32'(state), 32'd0);

        // unsupported opcode
        opcode = 6'b111111;
        tick();
        chk("ill_state",   32'(state), 32'd1);
        chk("ill_flag",    32'(illegal_op), 32'd1);
        tick();
        chk("ill_next",    32'(state), 32'd0);
        chk("ill_cleared", 32'(illegal_op), 32'd0);

        // addi: supported only when the feature macro is defined
        opcode = 6'b001000;
        tick();
`ifdef MULTICYCLE_CTRL_ADDI_EN
        chk("addi_d_flag", 32'(illegal_op), 32'd0);
        tick();
        chk("addi_ex_state", 32'(state), 32'd10);
        chk("addi_ex_src_b", 32'(alu_src_b), 32'd2);
        chk("addi_ex_src_a", 32'(alu_src_a), 32'd1);
        tick();
        chk("addi_wb_state", 32'(state), 32'd11);
        chk("addi_wb_regw",  32'(reg_write), 32'd1);
        chk("addi_wb_rdst",  32'(reg_dst), 32'd0);
        tick();
        chk("addi_end_state", 32'(state), 32'd0);
`else
        chk("addi_d_flag", 32'(illegal_op), 32'd1);
        tick();
        chk("addi_ill_next", 32'(state), 32'd0);
`endif

        // reset asserted while stalled in MEM_RD
        opcode    = 6'b100011;
        mem_ready = 1'b1;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        chk("rmid_pre_state", 32'(state), 32'd3);
        reset = 1'b1;
        #1;
        chk("rmid_state", 32'(state), 32'd0);
        chk("rmid_regw",  32'(reg_write), 32'd0);
        chk("rmid_pc_en", 32'(pc_en), 32'd0);
        mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rmid_hold_state", 32'(state), 32'd0);
            chk("rmid_hold_regw",  32'(reg_write), 32'd0);
            chk("rmid_hold_pc_en", 32'(pc_en), 32'd0);
            chk("rmid_hold_irw",   32'(ir_write), 32'd0);
        end
        reset = 1'b0;
        #1;
        chk("rmid_rel_state", 32'(state), 32'd0);
        chk("rmid_rel_irw",   32'(ir_write), 32'd1);
        tick();
        chk("rmid_restart", 32'(state), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control sequencer for the MIPS32 multi-cycle datapath. It steps each instruction through fetch, decode, execute, memory and writeback states. In every cycle it drives the ALU operation class (`alu_op`) to the ALU control decoder, along with the mux selects and write enables for the PC, IR, register file and memory. Memory states stall on a single-bit ready handshake.

## Interface
Parameters:
- none

Ports:
- `clk` — input, 1 — the single clock; all state updates on its rising edge
- `reset` — input, 1 — asynchronous, active-high
- `opcode` — input, 6 — IR[31:26]
- `zero` — input, 1 — ALU zero flag
- `mem_ready` — input, 1 — memory access complete this cycle
- `pc_write` — output, 1 — unconditional PC load
- `pc_write_cond` — output, 1 — conditional PC load (beq)
- `pc_en` — output, 1 — `pc_write | (pc_write_cond & zero)`
- `pc_source` — output, 2 — 00 ALU result, 01 ALUOut, 10 jump target
- `i_or_d` — output, 1 — 0 memory address from PC, 1 from ALUOut
- `mem_read`, `mem_write`, `ir_write`, `reg_write` — output, 1 each — strobes
- `reg_dst` — output, 1 — 0 rt, 1 rd
- `mem_to_reg` — output, 1 — 0 ALUOut, 1 MDR
- `alu_src_a` — output, 1 — 0 PC, 1 register A
- `alu_src_b` — output, 2 — 00 B, 01 constant 4, 10 sign-extended imm, 11 imm<<2
- `alu_op` — output, 3 — 000 add, 001 subtract, 010 R-type funct decode
- `illegal_op` — output, 1 — unsupported opcode seen in DECODE
- `state` — output, 4 — current state, for debug

## Operation
**Machine type**
- Moore FSM, 4-bit state register.
- Outputs are a combinational function of state, plus `mem_ready` and `zero` where noted.
- Any output not listed for a state is 0.

**States and outputs**
- FETCH(0): `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=000, `pc_source`=00. `ir_write` and `pc_write` both equal `mem_ready`. Exits to DECODE when `mem_ready`=1, else holds.
- DECODE(1): `alu_src_a`=0, `alu_src_b`=11, `alu_op`=000. Branches on opcode:
  - 100011 (lw) or 101011 (sw) → MEM_ADDR
  - 000000 (R-type) → R_EX
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - 001000 (addi) → ADDI_EX
  - any other opcode → FETCH, with `illegal_op`=1 for this cycle
- MEM_ADDR(2): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=000. Next is MEM_RD for lw, MEM_WR for sw.
- MEM_RD(3): `mem_read`=1, `i_or_d`=1. Holds until `mem_ready`, then MEM_WB.
- MEM_WB(4): `reg_dst`=0, `mem_to_reg`=1, `reg_write`=1. Next is FETCH.
- MEM_WR(5): `mem_write`=1, `i_or_d`=1. Holds until `mem_ready`, then FETCH.
- R_EX(6): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=010. Next is R_WB.
- R_WB(7): `reg_dst`=1, `mem_to_reg`=0, `reg_write`=1. Next is FETCH.
- BRANCH(8): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=001, `pc_write_cond`=1, `pc_source`=01. Next is FETCH.
- JUMP(9): `pc_write`=1, `pc_source`=10. Next is FETCH.
- ADDI_EX(10): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=000. Next is ADDI_WB.
- ADDI_WB(11): `reg_dst`=0, `mem_to_reg`=0, `reg_write`=1. Next is FETCH.

**Error and reset handling**
- Unused encodings 12–15 return to FETCH on the next edge.
- `opcode` is sampled only in DECODE and MEM_ADDR. It is stable there because IR loads only in FETCH.

## Timing
**Reset**
- `reset` high forces `state`=FETCH immediately (asynchronous).
- While `reset` is high, `pc_write`, `pc_en`, `ir_write`, `reg_write`, `mem_write` and `illegal_op` are forced to 0.
- While `reset` is high, all other outputs take their FETCH values.
- Reset mid-instruction abandons it; no writeback occurs.

**Cycles per instruction (`mem_ready` held at 1)**
- lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each `mem_ready`=0 cycle in FETCH, MEM_RD or MEM_WR adds one cycle.

**Handshake**
- PC and IR update on exactly the edge at which FETCH sees `mem_ready`=1.
- Memory strobes stay asserted and stable for the whole wait.

**Branch**
- `pc_en` in BRANCH follows `zero` in the same cycle.

## Configuration
- Macro `MULTICYCLE_CTRL_ADDI_EN`.
- Defined: addi (001000) is supported through ADDI_EX and ADDI_WB.
- Undefined:
  - ADDI states are not compiled.
  - Opcode 001000 takes the illegal path (DECODE→FETCH, `illegal_op`=1).
  - Encodings 10 and 11 behave like the other unused encodings.

## Test plan
- Reset: assert `reset` mid-MEM_RD → `state`=0 immediately; `reg_write`=0 and `pc_en`=0 throughout.
- lw (opcode 100011), `mem_ready`=1:
  - state sequence 0,1,2,3,4,0 over 5 cycles;
  - `reg_write`=1 and `mem_to_reg`=1 only in state 4.
- sw (opcode 101011), with `mem_ready`=0 for 3 cycles in MEM_WR:
  - `mem_write`=1 for 4 consecutive cycles;
  - then `state`=0.
- beq (opcode 000100):
  - `zero`=1 → `pc_en`=1, `pc_source`=01, `alu_op`=001 in state 8;
  - `zero`=0 → `pc_en`=0.
- R-type: opcode 000000 → `alu_op`=010 in state 6, then `reg_dst`=1 and `reg_write`=1 in state 7.
- Opcode 111111 → `illegal_op`=1 for one cycle in DECODE, next `state`=0.
- Opcode 001000: with macro → states 10,11; without → illegal path.
